// File: rtl/dsp_mac_seq_if.sv
// Bundle of the job, sample-stream, result and DSP-slice signals of the MAC sequencer.
// The slave side is the sequencer; the master side is its environment (source, sink and DSP slice).
interface dsp_mac_seq_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic             in_ready;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_rstp;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic [47:0]      res_data;
    logic             res_ready;
    logic             busy;

    modport master (
        output start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        input  in_ready, dsp_a, dsp_b, dsp_opmode, dsp_rstp, res_valid, res_data, busy
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, dsp_p, res_ready,
        output in_ready, dsp_a, dsp_b, dsp_opmode, dsp_rstp, res_valid, res_data, busy
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequencer that runs an external DSP48 slice (A1/B1/M/P/OPMODE registered) as an
// unsigned multiply-accumulator for one dot-product job at a time.
module dsp_mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    dsp_mac_seq_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam logic [7:0] OPM_ADD  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;
    logic [LEN_W-1:0] cnt_inc;
    logic             drain_tag;
    logic             drain_tag_next;
    logic [7:0]       opmode_q;
    logic [7:0]       opmode_next;
    logic             rstp_q;
    logic             rstp_next;
    logic             accept;

    // Handshakes: a sample pair moves on a cycle where in_valid and in_ready are both
    // high, and in_ready never depends on in_valid; a result is offered while res_valid
    // is high and retires on the first cycle res_ready is also high.
    assign bus.in_ready  = (state == RUN) && (cnt != len_q);
    assign accept        = bus.in_valid && bus.in_ready;
    assign cnt_inc       = cnt + LEN_W'(accept);

    assign bus.dsp_a      = bus.in_a;
    assign bus.dsp_b      = bus.in_b;
    assign bus.dsp_opmode = opmode_q;
    assign bus.dsp_rstp   = rstp_q;
    assign bus.res_valid  = (state == DONE);
    assign bus.res_data   = bus.dsp_p;
    assign bus.busy       = (state != IDLE);
    assign dbg_state      = state;

    always_comb begin
        state_next     = state;
        len_next       = len_q;
        cnt_next       = cnt;
        drain_tag_next = drain_tag;
        rstp_next      = 1'b0;
        // The add opcode lines up with the product through the DSP's A1/B1 and M stages.
        opmode_next    = accept ? OPM_ADD : OPM_HOLD;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    len_next   = bus.len;
                    cnt_next   = '0;
                    rstp_next  = 1'b1;
                end
            end
            RUN: begin
                cnt_next = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_next     = DRAIN;
                    drain_tag_next = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_tag) begin
                    state_next = DONE;
                end else begin
                    drain_tag_next = 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            drain_tag <= 1'b0;
            opmode_q  <= OPM_HOLD;
            rstp_q    <= 1'b0;
        end else begin
            state     <= state_next;
            len_q     <= len_next;
            cnt       <= cnt_next;
            drain_tag <= drain_tag_next;
            opmode_q  <= opmode_next;
            rstp_q    <= rstp_next;
        end
    end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: a behavioural DSP48 slice closes the loop, and each job's
// expected result is the plain sum of products of its pairs.
module tb_dsp_mac_seq;
    localparam int LEN_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    dsp_mac_seq_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_seq #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // DSP slice: A1/B1 -> M -> P, with OPMODE registered inside the slice.
    logic [17:0] a1 = '0;
    logic [17:0] b1 = '0;
    logic [35:0] m = '0;
    logic [7:0]  opm_r = 8'h08;
    logic [47:0] p = 48'h0000_1234_5678;

    always @(posedge clk) begin
        a1    <= bus.dsp_a;
        b1    <= bus.dsp_b;
        m     <= 36'(a1) * 36'(b1);
        opm_r <= bus.dsp_opmode;
        if (bus.dsp_rstp) p <= '0;
        else if (opm_r == 8'h09) p <= p + 48'(m);
        else if (opm_r != 8'h08) p <= 48'hBAD0_BAD0_BAD0;
    end
    assign bus.dsp_p = p;

    logic [47:0] exp_q[$];
    logic        prev_acc = 1'b0;
    logic        first_run = 1'b0;
    logic [17:0] pa[256];
    logic [17:0] pb[256];
    int          gap[256];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int i, input logic [17:0] a, input logic [17:0] b, input int g);
        pa[i]  = a;
        pb[i]  = b;
        gap[i] = g;
    endtask

    // One clock cycle: drive the stream inputs, check per-cycle outputs, advance.
    task automatic drive_cycle(input logic v, input logic [17:0] a, input logic [17:0] b,
                               input logic exp_rdy);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        chk("in_ready", 48'(bus.in_ready), 48'(exp_rdy));
        chk("dsp_opmode", 48'(bus.dsp_opmode), prev_acc ? 48'h09 : 48'h08);
        chk("dsp_rstp", 48'(bus.dsp_rstp), 48'(first_run));
        chk("dsp_a_copy", 48'(bus.dsp_a), 48'(a));
        chk("dsp_b_copy", 48'(bus.dsp_b), 48'(b));
        prev_acc  = v && exp_rdy;
        first_run = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_job(input int n);
        logic [47:0] sum;
        sum = '0;
        for (int i = 0; i < n; i++) sum += 48'(pa[i]) * 48'(pb[i]);
        exp_q.push_back(sum);
        chk("idle_busy", 48'(bus.busy), 48'd0);
        chk("idle_res_valid", 48'(bus.res_valid), 48'd0);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        drive_cycle(1'b0, 18'd0, 18'd0, 1'b0);
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
        first_run = 1'b1;
        chk("run_busy", 48'(bus.busy), 48'd1);
    endtask

    task automatic feed_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i]; g++)
                drive_cycle(1'b0, 18'($urandom), 18'($urandom), 1'b1);
            drive_cycle(1'b1, pa[i], pb[i], 1'b1);
        end
    endtask

    task automatic finish_job(input int n, input int hold, input int start_at,
                              input logic ack_start);
        int          waited;
        logic [47:0] exp;
        waited = 0;
        exp = exp_q.pop_front();
        while (bus.res_valid !== 1'b1 && waited < 12) begin
            drive_cycle(1'($urandom_range(0, 1)), 18'($urandom), 18'($urandom), 1'b0);
            waited++;
        end
        chk("result_latency", 48'(waited), (n == 0) ? 48'd3 : 48'd2);
        for (int k = 0; k < hold; k++) begin
            chk("hold_res_valid", 48'(bus.res_valid), 48'd1);
            chk("hold_res_data", bus.res_data, exp);
            chk("hold_busy", 48'(bus.busy), 48'd1);
            bus.start = (k == start_at);
            drive_cycle(1'b0, 18'($urandom), 18'($urandom), 1'b0);
            bus.start = 1'b0;
        end
        chk("res_valid", 48'(bus.res_valid), 48'd1);
        chk("res_data", bus.res_data, exp);
        bus.res_ready = 1'b1;
        bus.start     = ack_start;
        drive_cycle(1'b0, 18'($urandom), 18'($urandom), 1'b0);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        chk("ack_busy", 48'(bus.busy), 48'd0);
        chk("ack_res_valid", 48'(bus.res_valid), 48'd0);
        if (ack_start) begin
            drive_cycle(1'b0, 18'd0, 18'd0, 1'b0);
            chk("start_ignored_busy", 48'(bus.busy), 48'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 48'(bus.busy), 48'd0);
        chk("reset_in_ready", 48'(bus.in_ready), 48'd0);
        chk("reset_res_valid", 48'(bus.res_valid), 48'd0);
        chk("reset_opmode", 48'(bus.dsp_opmode), 48'h08);
        chk("reset_rstp", 48'(bus.dsp_rstp), 48'd0);
        rst = 1'b0;
        drive_cycle(1'b0, 18'd0, 18'd0, 1'b0);

        // Three back-to-back pairs: 2*3 + 4*5 + 6*7 = 68.
        load(0, 18'd2, 18'd3, 0);
        load(1, 18'd4, 18'd5, 0);
        load(2, 18'd6, 18'd7, 0);
        start_job(3);
        feed_pairs(3);
        finish_job(3, 0, -1, 1'b0);

        // Two-cycle bubble between the pairs: 1000000 + 9.
        load(0, 18'd1000, 18'd1000, 0);
        load(1, 18'd3, 18'd3, 2);
        start_job(2);
        feed_pairs(2);
        finish_job(2, 0, -1, 1'b0);

        // Empty job.
        start_job(0);
        finish_job(0, 0, -1, 1'b0);

        // Longest job with full-scale operands.
        for (int i = 0; i < 255; i++) load(i, 18'h3FFFF, 18'h3FFFF, 0);
        start_job(255);
        feed_pairs(255);
        finish_job(255, 0, -1, 1'b0);

        // Reset after two of four pairs, then a fresh single-pair job.
        for (int i = 0; i < 4; i++) load(i, 18'($urandom), 18'($urandom), 0);
        start_job(4);
        drive_cycle(1'b1, pa[0], pb[0], 1'b1);
        drive_cycle(1'b1, pa[1], pb[1], 1'b1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("midjob_rst_busy", 48'(bus.busy), 48'd0);
        chk("midjob_rst_in_ready", 48'(bus.in_ready), 48'd0);
        chk("midjob_rst_res_valid", 48'(bus.res_valid), 48'd0);
        chk("midjob_rst_opmode", 48'(bus.dsp_opmode), 48'h08);
        chk("midjob_rst_rstp", 48'(bus.dsp_rstp), 48'd0);
        void'(exp_q.pop_back());
        prev_acc = 1'b0;
        drive_cycle(1'b0, 18'd0, 18'd0, 1'b0);
        load(0, 18'd5, 18'd5, 0);
        start_job(1);
        feed_pairs(1);
        finish_job(1, 0, -1, 1'b0);

        // Result held for ten cycles with START pulsed, then START alongside RES_READY.
        load(0, 18'($urandom), 18'($urandom), 1);
        load(1, 18'($urandom), 18'($urandom), 0);
        start_job(2);
        feed_pairs(2);
        finish_job(2, 10, 3, 1'b1);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++)
                load(i, 18'($urandom), 18'($urandom), $urandom_range(0, 2));
            start_job(n);
            feed_pairs(n);
            finish_job(n, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001: Parameter LEN_W, default 8, is the width of the vector-length input.
REQ-002: CLK  input  1  is the single clock; all state updates on its rising edge.
REQ-003: RST  input  1  is a synchronous, active-high reset.
REQ-004: START  input  1  is a pulse that begins a dot-product job; it is sampled only in IDLE.
REQ-005: LEN  input  LEN_W  is the number of sample pairs in the job, captured on START.
REQ-006: IN_VALID  input  1  marks a valid sample pair on IN_A and IN_B.
REQ-007: IN_A, IN_B  input  18 each  are the unsigned operands.
REQ-008: IN_READY  output  1  is high when the block accepts a pair; a pair is accepted when IN_VALID and IN_READY are both high.
REQ-009: DSP_A, DSP_B  output  18 each  drive DSP A and B, and are combinational copies of IN_A and IN_B.
REQ-010: DSP_OPMODE  output  8  drives DSP OPMODE and is registered.
REQ-011: DSP_RSTP  output  1  drives the DSP P-register reset and is registered.
REQ-012: DSP_P  input  48  is the DSP P output.
REQ-013: RES_VALID  output  1  and RES_DATA  output  48  carry the job result, with RES_DATA as a combinational copy of DSP_P.
REQ-014: RES_READY  input  1  is the result acknowledge.
REQ-015: BUSY  output  1  is high whenever the state is not IDLE.

Function
REQ-016: The target DSP shall be configured as A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT", with CE inputs tied high.
REQ-017: The FSM shall have four states, IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN on START, latching LEN and clearing the sample counter.
- RUN->DRAIN on the first cycle the counter equals the latched LEN, with the counter value registered.
- DRAIN->DONE after exactly 2 DRAIN cycles.
- DONE->IDLE when RES_READY is high.
REQ-018: DSP_RSTP shall be 1 during the first RUN cycle only, and 0 otherwise.
REQ-019: IN_READY shall equal (state==RUN && counter!=LEN) and is independent of IN_VALID.
REQ-020: The counter shall increment by 1 per accepted pair and never exceed LEN.
REQ-021: DSP_OPMODE shall be 8'h09 (X=M, Z=P, add, carry 0, pre-adder bypassed) in the cycle immediately after an accepted pair, and 8'h08 (X=0, Z=P, hold) in every other cycle.
REQ-022: Bubbles (IN_VALID low in RUN) shall produce an 8'h08 cycle and leave P unchanged.
REQ-023: Latency: if the last pair is accepted in cycle t, DONE and RES_VALID shall begin at cycle t+3, when DSP_P holds the full sum.
REQ-024: RES_VALID shall equal (state==DONE); DSP_OPMODE=8'h08 in DONE keeps RES_DATA stable until acknowledge.
REQ-025: Arithmetic shall be an unsigned sum of IN_A*IN_B modulo 2^48; with LEN_W=8 overflow is impossible.
REQ-026: LEN=0 shall accept no pairs, with the sequence START at s -> RUN s+1 (P cleared) -> DRAIN s+2..s+3 -> DONE s+4 with RES_DATA=0.
REQ-027: START shall be ignored outside IDLE, including when START and RES_READY arrive together in DONE.
REQ-028: A new START shall be accepted no earlier than the cycle after the return to IDLE.

Reset
REQ-029: On RST, the following shall hold next cycle, regardless of state:
- State is IDLE, and the counter and pipeline tag are cleared.
- DSP_OPMODE=8'h08 and DSP_RSTP=0.
- IN_READY=0, RES_VALID=0 and BUSY=0.
REQ-030: RST mid-job shall abandon the job with no RES_VALID; the next job's RSTP clears the stale P.

Verification
REQ-031: LEN=3 with pairs (2,3), (4,5), (6,7) on consecutive cycles from s+1 -> RES_VALID at s+6 and RES_DATA=68.
REQ-032: LEN=2 with pairs (1000,1000) and (3,3) and IN_VALID low for 2 cycles between them -> RES_DATA=1000009, and DSP_OPMODE=8'h08 during the bubble-following cycles.
REQ-033: LEN=0 -> no IN_READY, RES_VALID at s+4, RES_DATA=0.
REQ-034: LEN=255 with all pairs (2^18-1, 2^18-1) -> RES_DATA=255*68718952449=17523332874495, with no wrap.
REQ-035: RST asserted after 2 of 4 pairs, then a LEN=1 job with pair (5,5) -> RES_DATA=25.
REQ-036: RES_READY held low for 10 DONE cycles with START pulsed -> RES_DATA constant, START ignored, IDLE one cycle after RES_READY.
